// File: rtl/blink_sequencer.sv
// Replays a small table of (ontime, offtime, reps) blink steps into the pattern
// generator through its enable/done handshake, with an idle gap between steps.
module blink_sequencer #(
    parameter int NSTEPS  = 8,
    parameter int TW      = 32,
    parameter int RW      = 8,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 2**24,
    localparam int AW     = $clog2(NSTEPS)
) (
    input  logic          hwclk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [TW-1:0] wr_ontime,
    input  logic [TW-1:0] wr_offtime,
    input  logic [RW-1:0] wr_reps,
    input  logic [AW:0]   seq_len,
    input  logic          start,
    input  logic          abort,
    input  logic          pat_done,
    output logic          pat_enable,
    output logic [TW-1:0] pat_ontime,
    output logic [TW-1:0] pat_offtime,
    output logic [RW-1:0] pat_reps,
    output logic [AW-1:0] step,
    output logic          busy,
    output logic          seq_done,
    output logic          error
);

    localparam int            WDW      = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [AW:0]   NMAX     = (AW+1)'(NSTEPS);
    // The LOAD cycle of the next step is the last low cycle of the gap,
    // so the GAP state itself only lasts GAP-1 cycles.
    localparam logic [7:0]    GAP_HOLD = 8'(GAP - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_FINISH} state_t;

    state_t         state;
    logic [TW-1:0]  tbl_on   [NSTEPS];
    logic [TW-1:0]  tbl_off  [NSTEPS];
    logic [RW-1:0]  tbl_reps [NSTEPS];
    logic [AW:0]    len;
    logic [WDW-1:0] wd;
    logic [7:0]     gcnt;
    logic           last;

    assign last = (({1'b0, step} + (AW+1)'(1)) == len);

    always_ff @(posedge hwclk) begin
        if (wr_en && !busy) begin
            tbl_on[wr_addr]   <= wr_ontime;
            tbl_off[wr_addr]  <= wr_offtime;
            tbl_reps[wr_addr] <= wr_reps;
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            seq_done    <= 1'b0;
            error       <= 1'b0;
            pat_enable  <= 1'b0;
            step        <= '0;
            pat_ontime  <= '0;
            pat_offtime <= '0;
            pat_reps    <= '0;
            len         <= '0;
            wd          <= '0;
            gcnt        <= '0;
        end else begin
            seq_done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                pat_enable <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            len   <= (seq_len > NMAX) ? NMAX : seq_len;
                            step  <= '0;
                            error <= 1'b0;
                            busy  <= 1'b1;
                            if (seq_len == '0) begin
                                state    <= S_FINISH;
                                seq_done <= 1'b1;
                            end else begin
                                state <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        pat_ontime  <= tbl_on[step];
                        pat_offtime <= tbl_off[step];
                        pat_reps    <= tbl_reps[step];
                        wd          <= '0;
                        if (tbl_reps[step] == '0) begin
                            if (last) begin
                                state    <= S_FINISH;
                                seq_done <= 1'b1;
                            end else begin
                                step <= step + AW'(1);
                            end
                        end else begin
                            state      <= S_RUN;
                            pat_enable <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (pat_done) begin
                            pat_enable <= 1'b0;
                            gcnt       <= '0;
                            if (GAP_HOLD != 8'd0) begin
                                state <= S_GAP;
                            end else if (last) begin
                                state    <= S_FINISH;
                                seq_done <= 1'b1;
                            end else begin
                                step  <= step + AW'(1);
                                state <= S_LOAD;
                            end
                        end else if (wd == WD_LAST) begin
                            error      <= 1'b1;
                            pat_enable <= 1'b0;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            wd <= wd + WDW'(1);
                        end
                    end
                    S_GAP: begin
                        if (gcnt == GAP_HOLD - 8'd1) begin
                            if (last) begin
                                state    <= S_FINISH;
                                seq_done <= 1'b1;
                            end else begin
                                step  <= step + AW'(1);
                                state <= S_LOAD;
                            end
                        end else begin
                            gcnt <= gcnt + 8'd1;
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// Bench for blink_sequencer: directed table, random sequences against a trace model,
// and hand-written abort / watchdog / async-reset scenarios.
`timescale 1ns/1ps
module tb_blink_sequencer;

    localparam int NSTEPS = 8;
    localparam int TW     = 32;
    localparam int RW     = 8;
    localparam int AW     = 3;
    localparam int GAPV   = 4;
    localparam int TMO    = 20;

    logic          hwclk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [TW-1:0] wr_ontime = '0;
    logic [TW-1:0] wr_offtime = '0;
    logic [RW-1:0] wr_reps = '0;
    logic [AW:0]   seq_len = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pat_done = 1'b0;
    logic          pat_enable;
    logic [TW-1:0] pat_ontime;
    logic [TW-1:0] pat_offtime;
    logic [RW-1:0] pat_reps;
    logic [AW-1:0] step;
    logic          busy;
    logic          seq_done;
    logic          error;

    always #5 hwclk = ~hwclk;

    blink_sequencer #(.NSTEPS(NSTEPS), .TW(TW), .RW(RW), .GAP(GAPV), .TIMEOUT(TMO)) dut (
        .hwclk(hwclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_ontime(wr_ontime), .wr_offtime(wr_offtime), .wr_reps(wr_reps),
        .seq_len(seq_len), .start(start), .abort(abort), .pat_done(pat_done),
        .pat_enable(pat_enable), .pat_ontime(pat_ontime), .pat_offtime(pat_offtime),
        .pat_reps(pat_reps), .step(step), .busy(busy), .seq_done(seq_done), .error(error)
    );

    int vectors = 0;
    int miscompares = 0;
    int ton [NSTEPS];
    int toff[NSTEPS];
    int trep[NSTEPS];
    bit resp_on = 1'b1;
    int hc = 0;

    typedef struct {int busy; int en; int done; int step;} cyc_t;
    cyc_t expq[$];

    typedef struct {
        int on0, off0, r0, on1, off1, r1, on2, off2, r2;
        int slen, exp_busy, exp_bursts;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Stand-in for the pattern generator: done after (on+off)*reps enabled cycles.
    task automatic tick();
        int dur;
        @(posedge hwclk);
        #1;
        if (pat_enable && resp_on) begin
            hc++;
            dur = (int'(pat_ontime) + int'(pat_offtime)) * int'(pat_reps);
            pat_done = (hc == dur);
        end else begin
            hc = 0;
            pat_done = 1'b0;
        end
    endtask

    task automatic wr_entry(input int a, input int on, input int off, input int reps);
        wr_addr = AW'(a);
        wr_ontime = TW'(on);
        wr_offtime = TW'(off);
        wr_reps = RW'(reps);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        ton[a] = on;
        toff[a] = off;
        trep[a] = reps;
    endtask

    function automatic void push_c(input int b, input int e, input int d, input int s);
        cyc_t c;
        c.busy = b;
        c.en = e;
        c.done = d;
        c.step = s;
        expq.push_back(c);
    endfunction

    // Expected per-cycle trace, starting the cycle after start is sampled.
    function automatic void build(input int sl);
        int len;
        int fs;
        len = (sl > NSTEPS) ? NSTEPS : sl;
        expq.delete();
        for (int i = 0; i < len; i++) begin
            push_c(1, 0, 0, i);
            if (trep[i] != 0) begin
                repeat ((ton[i] + toff[i]) * trep[i]) push_c(1, 1, 0, i);
                repeat (GAPV - 1) push_c(1, 0, 0, i);
            end
        end
        fs = (len == 0) ? 0 : len - 1;
        push_c(1, 0, 1, fs);
        push_c(0, 0, 0, fs);
    endfunction

    task automatic run_seq(input int sl, output int nbusy, output int nburst);
        logic prev_en;
        build(sl);
        nbusy = 0;
        nburst = 0;
        prev_en = 1'b0;
        seq_len = (AW+1)'(sl);
        start = 1'b1;
        foreach (expq[k]) begin
            tick();
            if (k == 0) start = 1'b0;
            chk("busy", busy, expq[k].busy);
            chk("pat_enable", pat_enable, expq[k].en);
            chk("seq_done", seq_done, expq[k].done);
            chk("step", step, expq[k].step);
            chk("error", error, 0);
            if (expq[k].en != 0) begin
                chk("pat_ontime", pat_ontime, ton[expq[k].step]);
                chk("pat_offtime", pat_offtime, toff[expq[k].step]);
                chk("pat_reps", pat_reps, trep[expq[k].step]);
            end
            if (busy) nbusy++;
            if (pat_enable && !prev_en) nburst++;
            prev_en = pat_enable;
        end
    endtask

    task automatic write_a();
        wr_entry(0, 3, 2, 3);
        wr_entry(1, 1, 1, 1);
        wr_entry(2, 2, 2, 2);
    endtask

    initial begin
        int nb, nbu, ncnt, en_cnt;
        bit found, seen, sawdone;

        vecs[0] = '{3, 2, 3, 1, 1, 1, 2, 2, 2, 3, 38, 3};
        vecs[1] = '{3, 2, 3, 1, 1, 1, 2, 2, 2, 0, 1, 0};
        vecs[2] = '{3, 2, 3, 1, 1, 0, 2, 2, 2, 3, 33, 2};
        vecs[3] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 15, 41, 8};
        vecs[4] = '{2, 1, 2, 1, 1, 0, 1, 1, 0, 3, 13, 1};
        vecs[5] = '{3, 2, 3, 1, 1, 1, 2, 2, 2, 2, 26, 2};

        repeat (2) @(posedge hwclk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_enable", pat_enable, 0);
        chk("rst_done", seq_done, 0);
        chk("rst_error", error, 0);
        chk("rst_step", step, 0);
        chk("rst_ontime", pat_ontime, 0);
        reset = 1'b0;

        for (int i = 0; i < NSTEPS; i++) wr_entry(i, 1, 0, 1);

        foreach (vecs[v]) begin
            wr_entry(0, vecs[v].on0, vecs[v].off0, vecs[v].r0);
            wr_entry(1, vecs[v].on1, vecs[v].off1, vecs[v].r1);
            wr_entry(2, vecs[v].on2, vecs[v].off2, vecs[v].r2);
            run_seq(vecs[v].slen, nb, nbu);
            chk("busy_cycles", nb, vecs[v].exp_busy);
            chk("bursts", nbu, vecs[v].exp_bursts);
        end

        for (int r = 0; r < 6; r++) begin
            int sl, want;
            for (int i = 0; i < NSTEPS; i++)
                wr_entry(i, $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 3));
            sl = $urandom_range(0, 15);
            want = 0;
            for (int i = 0; i < ((sl > NSTEPS) ? NSTEPS : sl); i++)
                if (trep[i] != 0) want++;
            run_seq(sl, nb, nbu);
            chk("rand_bursts", nbu, want);
        end

        // start together with abort in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        seq_len = 4'd3;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        tick();
        chk("start_abort_busy2", busy, 0);

        // abort in the middle of step 1
        write_a();
        for (int i = 3; i < NSTEPS; i++) wr_entry(i, 1, 0, 1);
        seq_len = 4'd3;
        start = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            start = 1'b0;
            if (step == 3'd1 && pat_enable) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_reach_step1", found, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_enable", pat_enable, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", seq_done, 0);
        repeat (3) begin
            tick();
            chk("abort_no_done", seq_done, 0);
        end
        run_seq(3, nb, nbu);
        chk("abort_replay_bursts", nbu, 3);

        // watchdog with pat_done held low
        wr_entry(0, 1, 0, 1);
        resp_on = 1'b0;
        seq_len = 4'd1;
        start = 1'b1;
        en_cnt = 0;
        sawdone = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            start = 1'b0;
            if (pat_enable) en_cnt++;
            if (seq_done) sawdone = 1'b1;
            if (!busy) break;
        end
        chk("wd_enable_cycles", en_cnt, TMO);
        chk("wd_error", error, 1);
        chk("wd_busy", busy, 0);
        chk("wd_no_done", sawdone, 0);
        tick();
        chk("wd_error_sticky", error, 1);
        resp_on = 1'b1;
        run_seq(1, nb, nbu);
        chk("wd_restart_bursts", nbu, 1);

        // asynchronous reset during GAP of step 1; write while busy is dropped
        write_a();
        seq_len = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_addr = '0;
        wr_ontime = 32'd7;
        wr_offtime = 32'd7;
        wr_reps = 8'd7;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        found = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (step == 3'd1 && pat_enable) seen = 1'b1;
            if (seen && busy && !pat_enable) begin
                found = 1'b1;
                break;
            end
        end
        chk("gap_reached", found, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_enable", pat_enable, 0);
        chk("arst_busy", busy, 0);
        chk("arst_step", step, 0);
        chk("arst_ontime", pat_ontime, 0);
        chk("arst_offtime", pat_offtime, 0);
        chk("arst_reps", pat_reps, 0);
        chk("arst_done", seq_done, 0);
        tick();
        reset = 1'b0;
        ncnt = 0;
        run_seq(3, nb, nbu);
        chk("after_reset_busy_cycles", nb, 38);
        chk("after_reset_bursts", nbu, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
